maroc_sc_sequencer: RTL and testbench

MAROC_SC_SEQUENCER -- requirements
Module: maroc_sc_sequencer

---
 rtl/maroc_sc_pkg.sv | 38 +++
 rtl/maroc_sc_shadow_regs.sv | 40 ++++
 rtl/maroc_sc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_maroc_sc_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maroc_sc_pkg.sv
// Shared constants and encodings for the MAROC slow-control sequencer.
// States START2/WAIT_TX2 exist only when SC_READBACK_EN is defined.
package maroc_sc_pkg;

  localparam int unsigned FRAME_BITS = 829;
  localparam int unsigned WORD_BITS  = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StWaitTx = 3'd2,
    StDone   = 3'd3,
    StError  = 3'd4
`ifdef SC_READBACK_EN
    ,
    StStart2  = 3'd5,
    StWaitTx2 = 3'd6
`endif
  } sc_state_e;

  typedef enum logic [1:0] {
    TxIdle    = 2'd0,
    TxPrepare = 2'd1,
    TxSending = 2'd2,
    TxFinal   = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrTimeout  = 2'd1,
    ErrMismatch = 2'd2
  } err_code_e;

  function automatic int unsigned num_words(input int unsigned bits);
    return (bits + WORD_BITS - 1) / WORD_BITS;
  endfunction

endpackage

// File: rtl/maroc_sc_shadow_regs.sv
// Word-addressed shadow image of the slow-control frame. Writes to addresses
// past the last word match no word; bits above the frame length are dropped.
module maroc_sc_shadow_regs
  import maroc_sc_pkg::*;
#(
  parameter int unsigned FrameBits = FRAME_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [5:0]           wr_addr_i,
  input  logic [15:0]          wr_data_i,
  output logic [FrameBits-1:0] image_o
);

  localparam int unsigned NumWords = num_words(FrameBits);

  logic [FrameBits-1:0] image_d, image_q;

  for (genvar w = 0; w < NumWords; w++) begin : g_word
    logic sel;
    assign sel = wr_en_i && (wr_addr_i == 6'(w));
    for (genvar b = 0; b < WORD_BITS; b++) begin : g_bit
      if (w * WORD_BITS + b < FrameBits) begin : g_used
        assign image_d[w*WORD_BITS+b] = sel ? wr_data_i[b] : image_q[w*WORD_BITS+b];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      image_q <= '0;
    end else begin
      image_q <= image_d;
    end
  end

  assign image_o = image_q;

endmodule

// File: rtl/maroc_sc_sequencer.sv
// MAROC slow-control sequencer: shadow image, transmitter handshake and pass timeout.
// Defining SC_READBACK_EN adds a second pass that checks q_sc_in against the image.
module maroc_sc_sequencer
  import maroc_sc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2047,
  parameter int unsigned FRAME_BITS     = maroc_sc_pkg::FRAME_BITS
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  wr_en_in,
  input  logic [5:0]            wr_addr_in,
  input  logic [15:0]           wr_data_in,
  input  logic                  go_in,
  input  logic [1:0]            tx_state_in,
  input  logic                  q_sc_in,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  start_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [1:0]            err_code_out,
  output logic [9:0]            mismatch_cnt_out
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  sc_state_e         state_d, state_q;
  logic [TimerW-1:0] timer_d, timer_q;
  logic              seen_send_d, seen_send_q;
  logic              error_d, error_q;
  err_code_e         err_code_d, err_code_q;
  logic              shadow_we;

`ifdef SC_READBACK_EN
  localparam int unsigned     IdxW   = $clog2(FRAME_BITS + 1);
  localparam logic [IdxW-1:0] IdxEnd = IdxW'(FRAME_BITS);

  logic [IdxW-1:0] idx_d, idx_q;
  logic [9:0]      mismatch_d, mismatch_q;
`endif

  // The image is only writable while idle, which also freezes frame_out when busy.
  assign shadow_we = wr_en_in && (state_q == StIdle);

  maroc_sc_shadow_regs #(
    .FrameBits (FRAME_BITS)
  ) u_shadow (
    .clk_i     (clk_in),
    .rst_i     (reset_in),
    .wr_en_i   (shadow_we),
    .wr_addr_i (wr_addr_in),
    .wr_data_i (wr_data_in),
    .image_o   (frame_out)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    seen_send_d = seen_send_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
`ifdef SC_READBACK_EN
    idx_d       = idx_q;
    mismatch_d  = mismatch_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go_in) begin
          state_d    = StStart;
          error_d    = 1'b0;
          err_code_d = ErrNone;
`ifdef SC_READBACK_EN
          mismatch_d = '0;
`endif
        end
      end
      StStart: begin
        timer_d     = '0;
        seen_send_d = 1'b0;
        state_d     = StWaitTx;
      end
      StWaitTx: begin
        timer_d = timer_q + 1'b1;
        if (tx_state_in == TxSending) begin
          seen_send_d = 1'b1;
        end
        // Completion wins over a timeout landing on the same cycle.
        if (seen_send_q && (tx_state_in == TxFinal)) begin
`ifdef SC_READBACK_EN
          state_d = StStart2;
`else
          state_d = StDone;
`endif
        end else if (timer_q == TimerLast) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
`ifdef SC_READBACK_EN
      StStart2: begin
        timer_d     = '0;
        seen_send_d = 1'b0;
        idx_d       = '0;
        state_d     = StWaitTx2;
      end
      StWaitTx2: begin
        timer_d = timer_q + 1'b1;
        if (tx_state_in == TxSending) begin
          seen_send_d = 1'b1;
          if (idx_q != IdxEnd) begin
            idx_d = idx_q + 1'b1;
            if ((q_sc_in != frame_out[idx_q]) && (mismatch_q != 10'h3ff)) begin
              mismatch_d = mismatch_q + 1'b1;
            end
          end
        end
        if (seen_send_q && (tx_state_in == TxFinal)) begin
          if (mismatch_q != '0) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_code_d = ErrMismatch;
          end else begin
            state_d = StDone;
          end
        end else if (timer_q == TimerLast) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
`endif
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      seen_send_q <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ErrNone;
`ifdef SC_READBACK_EN
      idx_q       <= '0;
      mismatch_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      seen_send_q <= seen_send_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
`ifdef SC_READBACK_EN
      idx_q       <= idx_d;
      mismatch_q  <= mismatch_d;
`endif
    end
  end

  assign busy_out     = (state_q != StIdle);
  assign done_out     = (state_q == StDone);
  assign error_out    = error_q;
  assign err_code_out = err_code_q;

`ifdef SC_READBACK_EN
  assign start_out        = (state_q == StStart) || (state_q == StStart2);
  assign mismatch_cnt_out = mismatch_q;
`else
  logic unused_q_sc;
  assign unused_q_sc      = q_sc_in;
  assign start_out        = (state_q == StStart);
  assign mismatch_cnt_out = '0;
`endif

endmodule

// File: tb/tb_maroc_sc_sequencer.sv
// Directed self-checking bench for maroc_sc_sequencer; readback steps run only
// when SC_READBACK_EN is defined.
module tb_maroc_sc_sequencer;

  localparam int unsigned FB = 829;
  localparam int unsigned TO = 2047;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_PREP  = 2'd1;
  localparam logic [1:0] TX_SEND  = 2'd2;
  localparam logic [1:0] TX_FINAL = 2'd3;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          wr_en_in;
  logic [5:0]    wr_addr_in;
  logic [15:0]   wr_data_in;
  logic          go_in;
  logic [1:0]    tx_state_in;
  logic          q_sc_in;
  logic [FB-1:0] frame_out;
  logic          start_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;
  logic [1:0]    err_code_out;
  logic [9:0]    mismatch_cnt_out;

  int total = 0;
  int bad   = 0;
  logic [FB-1:0] exp_frame;

  maroc_sc_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .FRAME_BITS     (FB)
  ) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .wr_en_in         (wr_en_in),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .go_in            (go_in),
    .tx_state_in      (tx_state_in),
    .q_sc_in          (q_sc_in),
    .frame_out        (frame_out),
    .start_out        (start_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .error_out        (error_out),
    .err_code_out     (err_code_out),
    .mismatch_cnt_out (mismatch_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic check_frame(input string tag, input logic [FB-1:0] expv);
    total++;
    assert (frame_out === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, frame_out, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [15:0] data);
    wr_en_in   = 1'b1;
    wr_addr_in = addr;
    wr_data_in = data;
    step();
    wr_en_in   = 1'b0;
  endtask

  // Transmitter model, started right after the sequencer enters a wait state.
  // Returns just after the edge that samples FINAL.
  task automatic tx_pass(input int n_send, input int flip);
    tx_state_in = TX_PREP;
    step();
    tx_state_in = TX_SEND;
    for (int i = 0; i < n_send; i++) begin
      q_sc_in = (i < FB) ? (exp_frame[i] ^ (i == flip)) : 1'b0;
      step();
    end
    tx_state_in = TX_FINAL;
    step();
    tx_state_in = TX_IDLE;
    q_sc_in     = 1'b0;
  endtask

  initial begin
    reset_in    = 1'b1;
    wr_en_in    = 1'b0;
    wr_addr_in  = '0;
    wr_data_in  = '0;
    go_in       = 1'b0;
    tx_state_in = TX_IDLE;
    q_sc_in     = 1'b0;
    exp_frame   = '0;
    step();
    step();

    check("rst_busy", busy_out, 0);
    check("rst_start", start_out, 0);
    check("rst_done", done_out, 0);
    check("rst_error", error_out, 0);
    check("rst_errcode", err_code_out, 0);
    check("rst_mismatch", mismatch_cnt_out, 0);
    check_frame("rst_frame", '0);
    reset_in = 1'b0;
    step();

    // Word 0, last (partial) word, and an out-of-range address.
    wr(6'd0, 16'h0007);
    wr(6'd51, 16'hffff);
    wr(6'd60, 16'hffff);
    exp_frame[2:0]     = 3'b111;
    exp_frame[828:816] = '1;
    check_frame("img_writes", exp_frame);

    // Basic run: one start pulse, done after PREP + 2x SEND + FINAL.
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    check("r1_start", start_out, 1);
    check("r1_busy", busy_out, 1);
    step();
    check("r1_start_once", start_out, 0);
    check("r1_no_early_done", done_out, 0);
    tx_pass(2, -1);
    check("r1_done", done_out, 1);
    check("r1_frame_lo", frame_out[2:0], 3'b111);
    check("r1_no_err", error_out, 0);
    go_in = 1'b1;  // lands in the DONE cycle and must be ignored
    step();
    go_in = 1'b0;
    check("r1_done_pulse", done_out, 0);
    check("r1_idle", busy_out, 0);
    check("r1_go_in_done_ign", start_out, 0);
    step();
    check("r1_still_idle", busy_out, 0);

    // Writes and go while busy are ignored.
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    step();
    wr_en_in    = 1'b1;
    wr_addr_in  = 6'd1;
    wr_data_in  = 16'hffff;
    go_in       = 1'b1;
    tx_state_in = TX_PREP;
    step();
    wr_en_in = 1'b0;
    go_in    = 1'b0;
    check("r2_no_restart", start_out, 0);
    check_frame("r2_busy_write", exp_frame);
    tx_state_in = TX_SEND;
    step();
    step();
    tx_state_in = TX_FINAL;
    step();
    tx_state_in = TX_IDLE;
    check("r2_done", done_out, 1);
    step();
    check("r2_idle", busy_out, 0);

    // Stuck in SENDING: error exactly TO cycles after WAIT_TX is entered.
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    step();
    tx_state_in = TX_SEND;
    repeat (TO - 1) step();
    check("to_not_yet", error_out, 0);
    check("to_busy", busy_out, 1);
    step();
    check("to_error", error_out, 1);
    check("to_code", err_code_out, 1);
    check("to_no_done", done_out, 0);
    go_in = 1'b1;  // lands in the ERROR cycle and must be ignored
    step();
    go_in       = 1'b0;
    tx_state_in = TX_IDLE;
    check("to_idle", busy_out, 0);
    check("to_go_ign", start_out, 0);
    check("to_sticky", error_out, 1);
    check("to_sticky_code", err_code_out, 1);

    // Next go clears the error; reset mid-WAIT_TX aborts silently.
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    check("clr_error", error_out, 0);
    check("clr_code", err_code_out, 0);
    step();
    tx_state_in = TX_PREP;
    step();
    tx_state_in = TX_SEND;
    step();
    reset_in = 1'b1;
    #1;
    exp_frame = '0;
    check("ar_busy", busy_out, 0);
    check("ar_start", start_out, 0);
    check("ar_error", error_out, 0);
    check_frame("ar_frame", exp_frame);
    tx_state_in = TX_FINAL;
    step();
    reset_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_no_done", done_out, 0);
    end
    check("ar_idle", busy_out, 0);
    tx_state_in = TX_IDLE;

    // Normal run after reset.
    wr(6'd0, 16'h0007);
    exp_frame[2:0] = 3'b111;
    go_in = 1'b1;
    step();
    go_in = 1'b0;
    check("r5_start", start_out, 1);
    step();
    tx_pass(3, -1);
    check("r5_done", done_out, 1);
    check("r5_no_err", error_out, 0);
    step();
    check("r5_idle", busy_out, 0);

`ifdef SC_READBACK_EN
    wr(6'd6, 16'habcd);
    exp_frame[111:96] = 16'habcd;

    go_in = 1'b1;
    step();
    go_in = 1'b0;
    step();
    tx_pass(FB, -1);
    check("rb_start2", start_out, 1);
    step();
    tx_pass(FB, -1);
    check("rb_good_done", done_out, 1);
    check("rb_good_err", error_out, 0);
    check("rb_good_cnt", mismatch_cnt_out, 0);
    step();

    go_in = 1'b1;
    step();
    go_in = 1'b0;
    step();
    tx_pass(FB, -1);
    step();
    tx_pass(FB, 100);
    check("rb_bad_done", done_out, 0);
    check("rb_bad_err", error_out, 1);
    check("rb_bad_code", err_code_out, 2);
    check("rb_bad_cnt", mismatch_cnt_out, 1);
    step();
    check("rb_bad_idle", busy_out, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
